// File: rtl/atomrvcore_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_pkg
// Brief    : Shared constants and types for the AtomRV fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package atomrvcore_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/atomrvcore_ifu_if.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_ifu_if
// Brief    : Instruction-memory request/response bus between IFU and imem.
// Revision : 1.0 - initial release
// ============================================================================
interface atomrvcore_ifu_if #(
  parameter int DATAWIDTH = 32
);
  logic                 imem_req_o;
  logic [DATAWIDTH-1:0] imem_addr_o;
  logic                 imem_gnt_i;
  logic                 imem_rvalid_i;
  logic [DATAWIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/atomrvcore_fifo.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_fifo
// Brief    : Small synchronous FIFO with flush; flush overrides push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module atomrvcore_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i && !flush_i;
  assign w_pop  = pop_i && !flush_i && (r_count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rptr];
  assign count_o = r_count;
  assign full_o  = (r_count == FULL_COUNT);
  assign empty_o = (r_count == '0);

  // Producers are credit-gated, so a push into a full buffer is a design bug.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
                                        (push_i && !flush_i) |-> !full_o);

endmodule
`default_nettype wire

// File: rtl/atomrvcore_ifu.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_ifu
// Brief    : Instruction fetch stage: owns the PC, issues imem word reads and
//            buffers returned instr/PC pairs for decode; redirects flush.
// Revision : 1.0 - initial release
// ============================================================================
module atomrvcore_ifu #(
  parameter int          DATAWIDTH  = 32,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = atomrvcore_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR  = atomrvcore_pkg::NOP_INSTR
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  atomrvcore_ifu_if.master        imem,
  input  logic                    redirect_i,
  input  logic [DATAWIDTH-1:0]    redirect_pc_i,
  input  logic                    stall_i,
  output logic [DATAWIDTH-1:0]    instr_o,
  output logic [DATAWIDTH-1:0]    PC_o,
  output logic                    instr_valid_o
);

  import atomrvcore_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e           r_state;
  ifu_state_e           w_state_nxt;
  logic [DATAWIDTH-1:0] r_fetch_pc;
  logic [DATAWIDTH-1:0] w_fetch_pc_nxt;
  logic [CW-1:0]        r_discard;
  logic [CW-1:0]        w_discard_nxt;
  logic [CW-1:0]        w_outstanding;
  logic [CW-1:0]        w_outstanding_nxt;
  logic [CW-1:0]        w_fifo_count;
  logic [CW:0]          w_credit_used;
  logic                 w_handshake;
  logic                 w_rsp;
  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_pcq_empty;
  logic                 w_pcq_full;
  logic [DATAWIDTH-1:0] w_pcq_head;
  fetch_entry_t         w_entry;
  fetch_entry_t         w_head;
  logic                 w_unused_full;

  // Outstanding count lives in the in-flight PC queue: one entry per granted request.
  assign w_credit_used  = {1'b0, w_fifo_count} + {1'b0, w_outstanding};
  assign imem.imem_req_o  = !rst_i && !redirect_i && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem.imem_addr_o = r_fetch_pc;
  assign w_handshake    = imem.imem_req_o && imem.imem_gnt_i;
  assign w_rsp          = imem.imem_rvalid_i && !w_pcq_empty;

  assign instr_valid_o  = !w_fifo_empty;
  assign w_fifo_pop     = instr_valid_o && !stall_i;
  assign instr_o        = w_fifo_empty ? NOP_INSTR : w_head.instr;
  assign PC_o           = w_fifo_empty ? '0 : w_head.pc;
  assign w_unused_full  = w_fifo_full | w_pcq_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_discard  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_discard_nxt     = r_discard;
    w_outstanding_nxt = w_outstanding;
    w_fifo_push       = 1'b0;
    w_entry.pc        = w_pcq_head;
    w_entry.instr     = imem.imem_rdata_i;

    if (w_handshake) w_fetch_pc_nxt = r_fetch_pc + DATAWIDTH'(4);

    case ({w_handshake, w_rsp})
      2'b10:   w_outstanding_nxt = w_outstanding + CW'(1);
      2'b01:   w_outstanding_nxt = w_outstanding - CW'(1);
      default: w_outstanding_nxt = w_outstanding;
    endcase

    if (w_rsp) begin
      if (r_discard != '0) w_discard_nxt = r_discard - CW'(1);
      else                 w_fifo_push   = 1'b1;
    end

    case (r_state)
      RUN:     w_state_nxt = RUN;
      DRAIN:   if (w_discard_nxt == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase

    // Every fetch still in flight after this cycle belongs to the old path.
    if (redirect_i) begin
      w_fetch_pc_nxt = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
      w_discard_nxt  = w_outstanding_nxt;
      w_fifo_push    = 1'b0;
      w_state_nxt    = (w_outstanding_nxt != '0) ? DRAIN : RUN;
    end
  end

  atomrvcore_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_handshake),
    .wdata_i (r_fetch_pc),
    .pop_i   (w_rsp),
    .flush_i (1'b0),
    .rdata_o (w_pcq_head),
    .count_o (w_outstanding),
    .full_o  (w_pcq_full),
    .empty_o (w_pcq_empty)
  );

  atomrvcore_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_fifo_push),
    .wdata_i (w_entry),
    .pop_i   (w_fifo_pop),
    .flush_i (redirect_i),
    .rdata_o (w_head),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

endmodule
`default_nettype wire
